// File: rtl/var_decider_if.sv
// Decision request/response plus var_state read/write signals of var_decider.
// master = decider side, slave = solver control / var_state side.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 3
`endif

interface var_decider_if #(
  parameter int unsigned VAR_BITS = `MAX_VARS_BITS
);
  logic                start;
  logic                busy;
  logic                done;
  logic                found;
  logic [VAR_BITS-1:0] dec_var;
  logic                dec_val;
  logic                vs_read;
  logic                vs_write;
  logic [VAR_BITS-1:0] vs_var;
  logic                vs_val;
  logic                vs_unassign;
  logic                vs_val_in;
  logic                vs_unassign_in;

  modport master (
    input  start, vs_val_in, vs_unassign_in,
    output busy, done, found, dec_var, dec_val,
           vs_read, vs_write, vs_var, vs_val, vs_unassign
  );

  modport slave (
    output start, vs_val_in, vs_unassign_in,
    input  busy, done, found, dec_var, dec_val,
           vs_read, vs_write, vs_var, vs_val, vs_unassign
  );
endinterface

// File: rtl/var_decider.sv
// DPLL decision engine: scans var_state for the first unassigned variable and assigns it 0.
// Define VAR_DECIDER_ROTATE_EN to start each scan just past the last decided variable.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 3
`endif

module var_decider #(
  parameter int unsigned VAR_BITS = `MAX_VARS_BITS,
  parameter int unsigned NUM_VARS = 1 << VAR_BITS
) (
  input logic           clock_i,
  input logic           reset_i,
  var_decider_if.master bus
);
  localparam int unsigned         CNT_BITS = VAR_BITS + 1;
  localparam logic [VAR_BITS-1:0] LAST_IDX = VAR_BITS'(NUM_VARS - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(NUM_VARS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                found_q;
  logic                vs_read_q;
  logic                vs_write_q;
  logic [VAR_BITS-1:0] dec_var_q;
  logic [VAR_BITS-1:0] vs_var_q;
  logic [VAR_BITS-1:0] rp_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                tag_vld_q;
  logic                tag_last_q;
  logic [VAR_BITS-1:0] tag_var_q;

  logic [VAR_BITS-1:0] start_idx_d;
  logic                hit_d;
  logic                exhausted_d;
  logic                unused_vs_val_in;

  function automatic logic [VAR_BITS-1:0] wrap_inc(input logic [VAR_BITS-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + VAR_BITS'(1);
  endfunction

  // Returning read data is tagged with the index/valid of the read issued one cycle earlier.
  assign hit_d       = (state_q == S_SCAN) && tag_vld_q && bus.vs_unassign_in;
  assign exhausted_d = (state_q == S_SCAN) && tag_last_q && !bus.vs_unassign_in;

`ifdef VAR_DECIDER_ROTATE_EN
  logic [VAR_BITS-1:0] rot_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      rot_q <= '0;
    end else if (hit_d) begin
      rot_q <= wrap_inc(tag_var_q);
    end
  end

  assign start_idx_d = rot_q;
`else
  assign start_idx_d = '0;
`endif

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      vs_read_q  <= 1'b0;
      vs_write_q <= 1'b0;
      dec_var_q  <= '0;
      vs_var_q   <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      tag_vld_q  <= 1'b0;
      tag_last_q <= 1'b0;
      tag_var_q  <= '0;
    end else begin
      tag_vld_q  <= vs_read_q;
      tag_var_q  <= vs_var_q;
      tag_last_q <= vs_read_q && (cnt_q == CNT_FULL);
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // First read is issued on entry so it lands in the first SCAN cycle.
          if (bus.start) begin
            state_q   <= S_SCAN;
            busy_q    <= 1'b1;
            vs_read_q <= 1'b1;
            vs_var_q  <= start_idx_d;
            rp_q      <= wrap_inc(start_idx_d);
            cnt_q     <= CNT_BITS'(1);
          end
        end
        S_SCAN: begin
          if (hit_d) begin
            state_q    <= S_WRITE;
            found_q    <= 1'b1;
            dec_var_q  <= tag_var_q;
            vs_read_q  <= 1'b0;
            vs_write_q <= 1'b1;
            vs_var_q   <= tag_var_q;
          end else if (exhausted_d) begin
            state_q   <= S_DONE;
            found_q   <= 1'b0;
            vs_read_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (cnt_q < CNT_FULL) begin
            vs_read_q <= 1'b1;
            vs_var_q  <= rp_q;
            rp_q      <= wrap_inc(rp_q);
            cnt_q     <= cnt_q + CNT_BITS'(1);
          end else begin
            vs_read_q <= 1'b0;
          end
        end
        S_WRITE: begin
          state_q    <= S_DONE;
          vs_write_q <= 1'b0;
          done_q     <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.dec_var     = dec_var_q;
  assign bus.dec_val     = 1'b0;
  assign bus.vs_read     = vs_read_q;
  assign bus.vs_write    = vs_write_q;
  assign bus.vs_var      = vs_var_q;
  assign bus.vs_val      = 1'b0;
  assign bus.vs_unassign = 1'b0;

  // Read polarity is only of interest to monitors.
  assign unused_vs_val_in = bus.vs_val_in;

endmodule

// File: tb/tb_var_decider.sv
// Self-checking bench for var_decider: var_state memory model plus a first-free-variable reference.
module tb_var_decider;
  localparam int unsigned VB = 3;
  localparam int unsigned N  = 1 << VB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  var_decider_if #(.VAR_BITS(VB)) bus ();
  var_decider #(.VAR_BITS(VB)) dut (.clock_i(clk), .reset_i(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // var_state memory: 1 = unassigned. Read data appears one cycle after the read strobe.
  bit mem [N];
  bit pend_vld = 1'b0;
  int pend_addr = 0;
  always @(negedge clk) begin
    bus.vs_val_in = 1'($urandom);
    if (pend_vld) bus.vs_unassign_in = mem[pend_addr];
    else          bus.vs_unassign_in = 1'($urandom);
    pend_vld  = bus.vs_read;
    pend_addr = int'(bus.vs_var);
    if (bus.vs_write) mem[int'(bus.vs_var)] = bus.vs_unassign;
  end

  // Reference: ordered search from the start index, modulo N.
  bit model_mem [N];
  int rot_m = 0;
  int m_found, m_idx, m_off, m_s, m_done, m_nrd;
  task automatic model_decide();
    int j;
`ifdef VAR_DECIDER_ROTATE_EN
    m_s = rot_m;
`else
    m_s = 0;
`endif
    m_found = 0; m_idx = 0; m_off = 0;
    for (int k = 0; k < N; k++) begin
      j = (m_s + k) % N;
      if (m_found == 0 && model_mem[j]) begin m_found = 1; m_idx = j; m_off = k; end
    end
    if (m_found != 0) begin
      model_mem[m_idx] = 1'b0;
      rot_m = (m_idx + 1) % N;
      m_done = 4 + m_off;
      m_nrd = (m_off + 2 < N) ? m_off + 2 : N;
    end else begin
      m_done = N + 2;
      m_nrd = N;
    end
  endtask

  task automatic load_mem(input logic [N-1:0] pat);
    for (int i = 0; i < N; i++) begin mem[i] = pat[i]; model_mem[i] = pat[i]; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rot_m = 0;
  endtask

  // Runs one decision from a negedge (cycle 0) and records what the DUT did.
  int o_done_cyc, o_found, o_dec_var, o_dec_val, o_nreads, o_first_rd, o_rd_last_cyc, o_steps_bad;
  int o_nwrites, o_wr_cyc, o_wr_var, o_wr_bad, o_overlap, o_busy_cnt, o_done_pulses;
  task automatic run_decision(input bit poke);
    int prev_rd, stop_cyc;
    o_done_cyc = -1; o_found = -1; o_dec_var = -1; o_dec_val = -1;
    o_nreads = 0; o_first_rd = -1; o_rd_last_cyc = -1; o_steps_bad = 0;
    o_nwrites = 0; o_wr_cyc = -1; o_wr_var = -1; o_wr_bad = 0;
    o_overlap = 0; o_busy_cnt = 0; o_done_pulses = 0;
    prev_rd = -1; stop_cyc = N + 12;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= stop_cyc; cyc++) begin
      @(negedge clk);
      if (bus.vs_read) begin
        if (o_nreads == 0) o_first_rd = int'(bus.vs_var);
        else if (int'(bus.vs_var) != (prev_rd + 1) % N) o_steps_bad++;
        prev_rd = int'(bus.vs_var);
        o_nreads++;
        o_rd_last_cyc = cyc;
      end
      if (bus.vs_write) begin
        o_nwrites++; o_wr_cyc = cyc; o_wr_var = int'(bus.vs_var);
        if (bus.vs_val || bus.vs_unassign) o_wr_bad++;
      end
      if (bus.vs_read && bus.vs_write) o_overlap++;
      if (bus.busy) o_busy_cnt++;
      if (bus.done) begin
        o_done_pulses++;
        if (o_done_cyc < 0) begin
          o_done_cyc = cyc; o_found = int'(bus.found);
          o_dec_var = int'(bus.dec_var); o_dec_val = int'(bus.dec_val);
          stop_cyc = cyc + 3;
        end
      end
      bus.start = poke && bus.busy && !bus.done;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; rot_m = 0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset.busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset.done got=%b exp=0", bus.done); end
    checks++; if (bus.found !== 1'b0) begin failures++; $display("FAIL reset.found got=%b exp=0", bus.found); end
    checks++; if (bus.vs_read !== 1'b0) begin failures++; $display("FAIL reset.vs_read got=%b exp=0", bus.vs_read); end
    checks++; if (bus.vs_write !== 1'b0) begin failures++; $display("FAIL reset.vs_write got=%b exp=0", bus.vs_write); end
    checks++; if (bus.dec_var !== '0) begin failures++; $display("FAIL reset.dec_var got=%0d exp=0", bus.dec_var); end
    checks++; if (bus.vs_var !== '0) begin failures++; $display("FAIL reset.vs_var got=%0d exp=0", bus.vs_var); end
    checks++; if ({bus.dec_val, bus.vs_val, bus.vs_unassign} !== 3'b000) begin failures++; $display("FAIL reset.vals got=%b exp=000", {bus.dec_val, bus.vs_val, bus.vs_unassign}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset.idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_first_free();
    apply_reset(); load_mem(8'hFF); model_decide(); run_decision(1'b0);
    checks++; if (o_first_rd !== 0) begin failures++; $display("FAIL first_free.first_rd got=%0d exp=0", o_first_rd); end
    checks++; if (o_wr_cyc !== 3 || o_wr_var !== 0 || o_wr_bad !== 0) begin failures++; $display("FAIL first_free.write got=cyc%0d/var%0d/bad%0d exp=cyc3/var0/bad0", o_wr_cyc, o_wr_var, o_wr_bad); end
    checks++; if (o_done_cyc !== 4 || o_found !== 1 || o_dec_var !== 0) begin failures++; $display("FAIL first_free.done got=cyc%0d/f%0d/v%0d exp=cyc4/f1/v0", o_done_cyc, o_found, o_dec_var); end
  endtask

  task automatic test_mid_hit();
    apply_reset(); load_mem(8'hE0); model_decide(); run_decision(1'b0);
    checks++; if (o_wr_cyc !== 8 || o_wr_var !== 5) begin failures++; $display("FAIL mid_hit.write got=cyc%0d/var%0d exp=cyc8/var5", o_wr_cyc, o_wr_var); end
    checks++; if (o_done_cyc !== 9 || o_dec_var !== 5 || o_found !== 1) begin failures++; $display("FAIL mid_hit.done got=cyc%0d/v%0d/f%0d exp=cyc9/v5/f1", o_done_cyc, o_dec_var, o_found); end
    checks++; if (o_nreads !== 7 || o_rd_last_cyc !== 7 || o_nwrites !== 1) begin failures++; $display("FAIL mid_hit.reads got=n%0d/last%0d/w%0d exp=n7/last7/w1", o_nreads, o_rd_last_cyc, o_nwrites); end
    checks++; if (mem[6] !== 1'b1 || mem[5] !== 1'b0) begin failures++; $display("FAIL mid_hit.mem got=m5:%0d/m6:%0d exp=m5:0/m6:1", mem[5], mem[6]); end
  endtask

  task automatic test_all_assigned();
    apply_reset(); load_mem(8'h00); model_decide(); run_decision(1'b0);
    checks++; if (o_nreads !== 8 || o_first_rd !== 0 || o_rd_last_cyc !== 8 || o_steps_bad !== 0) begin failures++; $display("FAIL all_assigned.reads got=n%0d/first%0d/last%0d/steps%0d exp=n8/first0/last8/steps0", o_nreads, o_first_rd, o_rd_last_cyc, o_steps_bad); end
    checks++; if (o_nwrites !== 0) begin failures++; $display("FAIL all_assigned.writes got=%0d exp=0", o_nwrites); end
    checks++; if (o_done_cyc !== 10 || o_found !== 0) begin failures++; $display("FAIL all_assigned.done got=cyc%0d/f%0d exp=cyc10/f0", o_done_cyc, o_found); end
  endtask

  task automatic test_rotation();
    apply_reset(); load_mem(8'h04); model_decide(); run_decision(1'b0);
    checks++; if (o_dec_var !== 2) begin failures++; $display("FAIL rotation.first_dec got=%0d exp=2", o_dec_var); end
    load_mem(8'h02); model_decide(); run_decision(1'b0);
    checks++; if (o_first_rd !== m_s || o_steps_bad !== 0 || o_nreads !== m_nrd) begin failures++; $display("FAIL rotation.reads got=first%0d/steps%0d/n%0d exp=first%0d/steps0/n%0d", o_first_rd, o_steps_bad, o_nreads, m_s, m_nrd); end
    checks++; if (o_dec_var !== 1 || o_done_cyc !== m_done) begin failures++; $display("FAIL rotation.done got=v%0d/cyc%0d exp=v1/cyc%0d", o_dec_var, o_done_cyc, m_done); end
  endtask

  task automatic test_reset_mid_scan();
    load_mem(8'h00);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.vs_read !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL reset_mid_scan.idle got=busy%b/rd%b/done%b exp=0/0/0", bus.busy, bus.vs_read, bus.done); end
    rst_n = 1'b1; rot_m = 0;
    load_mem(8'h10); model_decide(); run_decision(1'b0);
    checks++; if (o_first_rd !== 0 || o_dec_var !== 4 || o_done_cyc !== m_done) begin failures++; $display("FAIL reset_mid_scan.rescan got=first%0d/v%0d/cyc%0d exp=first0/v4/cyc%0d", o_first_rd, o_dec_var, o_done_cyc, m_done); end
  endtask

  task automatic test_busy_ignore();
    load_mem(8'h20); model_decide(); run_decision(1'b1);
    checks++; if (o_done_pulses !== 1 || o_nwrites !== 1) begin failures++; $display("FAIL busy_ignore.pulses got=done%0d/w%0d exp=done1/w1", o_done_pulses, o_nwrites); end
    checks++; if (o_done_cyc !== m_done || o_dec_var !== m_idx || o_busy_cnt !== m_done) begin failures++; $display("FAIL busy_ignore.result got=cyc%0d/v%0d/busy%0d exp=cyc%0d/v%0d/busy%0d", o_done_cyc, o_dec_var, o_busy_cnt, m_done, m_idx, m_done); end
  endtask

  task automatic test_back_to_back();
    int d1, v1, d2, v2, n, got1, gv1, got2, gv2;
    load_mem(8'hFF);
    model_decide(); d1 = m_done; v1 = m_idx;
    model_decide(); d2 = d1 + 1 + m_done; v2 = m_idx;
    n = 0; got1 = -1; gv1 = -1; got2 = -1; gv2 = -1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 4 * N + 20 && n < 2; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        n++;
        if (n == 1) begin got1 = cyc; gv1 = int'(bus.dec_var); end
        else begin got2 = cyc; gv2 = int'(bus.dec_var); bus.start = 1'b0; end
      end
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (got1 !== d1 || gv1 !== v1) begin failures++; $display("FAIL back_to_back.first got=cyc%0d/v%0d exp=cyc%0d/v%0d", got1, gv1, d1, v1); end
    checks++; if (got2 !== d2 || gv2 !== v2) begin failures++; $display("FAIL back_to_back.second got=cyc%0d/v%0d exp=cyc%0d/v%0d", got2, gv2, d2, v2); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL back_to_back.idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    logic [N-1:0] pat;
    int diffs;
    for (int it = 0; it < 25; it++) begin
      pat = N'($urandom);
      case ($urandom_range(0, 3))
        0: pat = '0;
        1: pat = pat & N'($urandom) & N'($urandom);
        2: begin pat = '0; pat[$urandom_range(0, N - 1)] = 1'b1; end
        default: ;
      endcase
      load_mem(pat); model_decide(); run_decision(1'($urandom));
      checks++; if (o_done_cyc !== m_done || o_found !== m_found) begin failures++; $display("FAIL random[%0d].done got=cyc%0d/f%0d exp=cyc%0d/f%0d", it, o_done_cyc, o_found, m_done, m_found); end
      checks++; if (o_nreads !== m_nrd || o_rd_last_cyc !== m_nrd || o_first_rd !== m_s || o_steps_bad !== 0) begin failures++; $display("FAIL random[%0d].reads got=n%0d/last%0d/first%0d/steps%0d exp=n%0d/last%0d/first%0d/steps0", it, o_nreads, o_rd_last_cyc, o_first_rd, o_steps_bad, m_nrd, m_nrd, m_s); end
      checks++; if (o_nwrites !== m_found) begin failures++; $display("FAIL random[%0d].nwrites got=%0d exp=%0d", it, o_nwrites, m_found); end
      if (m_found != 0) begin
        checks++; if (o_wr_cyc !== 3 + m_off || o_wr_var !== m_idx || o_dec_var !== m_idx) begin failures++; $display("FAIL random[%0d].hit got=wc%0d/wv%0d/dv%0d exp=wc%0d/v%0d", it, o_wr_cyc, o_wr_var, o_dec_var, 3 + m_off, m_idx); end
      end
      checks++; if (o_overlap !== 0 || o_wr_bad !== 0 || o_dec_val !== 0 || o_done_pulses !== 1) begin failures++; $display("FAIL random[%0d].misc got=ovl%0d/wbad%0d/dval%0d/pulses%0d exp=0/0/0/1", it, o_overlap, o_wr_bad, o_dec_val, o_done_pulses); end
      checks++; if (o_busy_cnt !== m_done) begin failures++; $display("FAIL random[%0d].busy_cycles got=%0d exp=%0d", it, o_busy_cnt, m_done); end
      diffs = 0;
      for (int i = 0; i < N; i++) if (mem[i] != model_mem[i]) diffs++;
      checks++; if (diffs !== 0) begin failures++; $display("FAIL random[%0d].mem got=%0d_diffs exp=0", it, diffs); end
    end
  endtask

  initial begin
    test_reset();
    test_first_free();
    test_mid_hit();
    test_all_assigned();
    test_rotation();
    test_reset_mid_scan();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/var_decider.md
# var_decider

Decision engine for the DPLL core: on request it scans the variable-state memory (`var_state`) for the first unassigned variable, then assigns it with the default polarity through the `var_state` write port. It drives the read port of `var_state` as initiator and consumes its read data, which is the other end of the `var_state` read/write interface. It reports the chosen variable to the solver control FSM, or reports that no unassigned variable remains (formula satisfied).

## Interface
- `VAR_BITS`, default `` `MAX_VARS_BITS ``: variable index width.
- `NUM_VARS`, default `1 << VAR_BITS`: number of variables scanned, indices 0..NUM_VARS-1.

- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clock`.
- `start`  in  1  request one decision. Sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the decision completes.
- `found`  out  1  valid with `done`: 1 means a variable was assigned, 0 means all variables are assigned.
- `dec_var`  out  VAR_BITS  chosen variable. Valid with `done`.
- `dec_val`  out  1  chosen polarity. Valid with `done`. Always 0.
- `vs_read`  out  1  read strobe to `var_state`.
- `vs_write`  out  1  write strobe to `var_state`.
- `vs_var`  out  VAR_BITS  address for both the read and the write.
- `vs_val`  out  1  write value. Always 0.
- `vs_unassign`  out  1  write unassign flag. Always 0.
- `vs_val_in`  in  1  read data from `var_state` (unused except for monitoring).
- `vs_unassign_in`  in  1  read data from `var_state`. Valid the cycle after `vs_read`.

## Operation
- States: IDLE, SCAN, WRITE, DONE.
- **IDLE**
  - `start`=1 → SCAN.
  - The read pointer `rp` loads the start index `s`, and the issued-count counter clears.
- **SCAN**
  - Each cycle, while issued-count < NUM_VARS: `vs_read`=1, `vs_var`=`rp`; then `rp` increments and issued-count increments.
  - A one-cycle-delayed copy of (`rp`, read-issued) tags the returning data.
  - If tagged data is valid and `vs_unassign_in`=1: the tagged index is captured into `dec_var` and the state goes to WRITE. The read issued that same cycle is speculative and discarded.
  - If the tagged data is for the final (NUM_VARS-th) read and is assigned: `found`=0 and the state goes to DONE.
- **WRITE**
  - One cycle with `vs_write`=1, `vs_var`=`dec_var`, `vs_val`=0, `vs_unassign`=0, `vs_read`=0. Then → DONE.
- **DONE**
  - One cycle with `done`=1, holding `found`/`dec_var`/`dec_val`. Then → IDLE.
- `rp` arithmetic is modulo NUM_VARS: it wraps from NUM_VARS-1 to 0. Issued-count is VAR_BITS+1 bits wide.
- `vs_read` and `vs_write` are never high in the same cycle.
- `start` outside IDLE is ignored. There is no queuing.

## Timing
- Reset (`reset`=0 at an edge) is effective at any state, including mid-scan or in WRITE. Values after reset:
  - state = IDLE;
  - `busy`, `done`, `found`, `vs_read`, `vs_write` = 0;
  - `dec_var`, `vs_var`, `dec_val`, `vs_val`, `vs_unassign` = 0;
  - rotation pointer = 0.
- Read latency assumed from `var_state`: 1 cycle.
- Let cycle 0 be the cycle in which `start` is sampled. For a hit at scan offset i:
  - read at cycle 1+i;
  - evaluate at 2+i;
  - `vs_write` at 3+i;
  - `done` at 4+i.
- No unassigned variable: last read at NUM_VARS, evaluate at NUM_VARS+1, `done` with `found`=0 at NUM_VARS+2, no write issued.
- `busy` goes high the cycle after `start` is sampled and drops in the cycle after `done`.
- `start` held high across DONE→IDLE begins a new decision in the next IDLE cycle.

## Configuration
- `VAR_DECIDER_ROTATE_EN` defined:
  - The start index `s` = (last assigned `dec_var` + 1) mod NUM_VARS.
  - This rotation pointer updates only on `found`=1. Reset sets it to 0.
- `VAR_DECIDER_ROTATE_EN` undefined:
  - `s` = 0 always. No rotation register exists.

## Test plan
- **Reset mid-scan:** `reset`=0 during SCAN (cycle 3) → the next cycle has state IDLE, `busy`=0, `vs_read`=0; a later `start` rescans from 0.
- **First variable free:** model with VAR_BITS=3 (NUM_VARS=8), all variables unassigned, `start` at cycle 0 → `vs_read` var 0 at cycle 1; `vs_write` var 0, val 0, unassign 0 at cycle 3; `done`=1, `found`=1, `dec_var`=0 at cycle 4.
- **Mid hit:** variables 0–4 assigned, 5 free → `vs_write` var 5 at cycle 8; `done` with `dec_var`=5 at cycle 9; the speculative read of var 6 at cycle 7 has no effect.
- **All assigned:** all 8 variables assigned → 8 reads (vars 0–7, cycles 1–8), no `vs_write`; `done`=1, `found`=0 at cycle 10.
- **Rotation (macro defined):** first decision assigns var 2; then, with var 2 assigned and var 1 free, `start` → reads begin at var 3 and wrap 7→0→1; `dec_var`=1. With the macro undefined, reads begin at var 0 and `dec_var`=1.
- **Busy ignore:** `start` pulsed during SCAN and WRITE → no extra decision; exactly one `done` pulse.
